// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter fed by a valid/ready stream through a small FIFO.
// Queued frames go out back-to-back; tx is registered and idles high.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_BITS-1:0]         in_data,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam int NW = PW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head, shift, shift_n;
    logic [CW-1:0]        baud, baud_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic                 par, par_n, tx_n, push, pop, baud_end, fifo_empty;

    assign in_ready   = fifo_count < NW'(FIFO_DEPTH);
    assign push       = in_valid && in_ready;
    assign fifo_empty = fifo_count == '0;
    assign head       = mem[rd_ptr];
    assign baud_end   = baud == CW'(CLKS_PER_BIT - 1);
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // Parity is latched from the popped character so shifting never disturbs it.
    always_comb begin
        state_n = state;
        baud_n  = baud_end ? '0 : baud + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                pop    = !fifo_empty;
            end
            START: if (baud_end) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA: if (baud_end) begin
                shift_n = shift >> 1;
                bit_n   = bit_cnt + 1'b1;
                if (bit_cnt == BW'(DATA_BITS - 1)) begin
                    state_n = (PARITY != 0) ? PARITY_BIT : STOP;
                    bit_n   = '0;
                end
            end
            PARITY_BIT: if (baud_end) begin
                state_n = STOP;
                bit_n   = '0;
            end
            STOP: if (baud_end) begin
                bit_n = bit_cnt + 1'b1;
                if (bit_cnt == BW'(STOP_BITS - 1)) begin
                    bit_n   = '0;
                    pop     = !fifo_empty;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            state_n = START;
            shift_n = head;
            par_n   = (PARITY == 2) ? ^head : ~^head;
        end
        tx_n = state_n == START      ? 1'b0 :
               state_n == DATA       ? shift_n[0] :
               state_n == PARITY_BIT ? par_n : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            par     <= par_n;
            tx      <= tx_n;
        end
    end
endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter with a valid/ready input stream, an internal FIFO, and a configurable frame format. It is the general-purpose TX path for any block that produces bytes and cannot wait for each frame to finish. It supports configurable baud divisor, data width, parity and stop bits, and sends queued frames back-to-back with no idle gap.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (≥2; 868 = 115200 baud at 100 MHz)
- DATA_BITS, 8, data bits per frame (5..8)
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 4, FIFO entries (power of two, ≥2)

- clk  input  1  clock
- reset  input  1  reset; asynchronous, active-low
- in_valid  input  1  in_data holds a character to send
- in_ready  output  1  FIFO can accept; transfer occurs at a rising edge with in_valid && in_ready
- in_data  input  DATA_BITS  character, LSB sent first
- tx  output  1  serial line, idle high, registered
- busy  output  1  high while FIFO is non-empty or a frame is in progress
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset values:
  - tx = 1, in_ready = 1, busy = 0, fifo_count = 0.
  - FIFO pointers and shift register are cleared; FSM is in IDLE.
- FIFO:
  - in_ready = (fifo_count < FIFO_DEPTH), combinational from count.
  - Pointers wrap modulo FIFO_DEPTH.
  - A write and a pop in the same cycle leave the count unchanged.
  - When full, in_ready = 0 even if a pop occurs that cycle.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: tx = 1. If FIFO non-empty, pop the head into the shift register and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0]; shift right every CLKS_PER_BIT cycles; after DATA_BITS bits go to PARITY if PARITY≠0, else STOP.
  - PARITY: tx = ^data for even, ~^data for odd, for one bit time.
  - STOP: tx = 1 for STOP_BITS×CLKS_PER_BIT cycles.
  - At the end of STOP: if FIFO non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state or bit change; bit ends when counter == CLKS_PER_BIT-1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Parity is computed from the popped character, never from the shifted register.
- busy = (state ≠ IDLE) || (fifo_count ≠ 0).

## Timing
- Transfer accepted at edge k:
  - fifo_count increments after edge k.
  - If IDLE, the pop happens at edge k+1, tx falls after k+1, and fifo_count decrements.
- Latency from acceptance to start-bit edge: 1 cycle when idle.
- In-flight capacity: FIFO_DEPTH queued + 1 in the shift register. With an idle FSM, FIFO_DEPTH+1 consecutive writes are accepted before in_ready drops.
- Back-to-back frames: the stop bit of frame n ends and the start bit of frame n+1 begins on the same edge.
- Reset asserted mid-frame:
  - tx goes to 1 asynchronously; the partial frame and FIFO contents are discarded.
  - After deassertion, nothing is transmitted until a new write.
- in_data is sampled only at the transfer edge; changes while in_ready = 0 are ignored.

## Test plan
- CLKS_PER_BIT=4, 8N1, write 0x55 once:
  - tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; total 40 cycles.
  - busy drops on the cycle after the stop bit.
- PARITY=2, write 0x07: parity bit = 1. PARITY=1, write 0x07: parity bit = 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- DATA_BITS=5, STOP_BITS=2, write 0x1F: start, five 1s, two stop bits; 32 cycles total at CLKS_PER_BIT=4.
- Hold in_valid high with 0xA1..0xA6, FIFO_DEPTH=4:
  - First 5 are accepted, then in_ready = 0 until the first frame's stop bit ends.
  - All 6 characters are sent in order with zero idle cycles between frames.
- Reset pulse during the DATA bit 3 of 0x3C, with 2 entries queued:
  - tx = 1 immediately and fifo_count = 0.
  - No further transitions on tx for 100 cycles after release.
- Simultaneous write and pop with fifo_count=2: count stays 2, and ordering is preserved in the output.
